// File: rtl/state_seq_pkg.sv
// rtl/state_seq_pkg.sv - shared mode encodings for the state sequencer
package state_seq_pkg;

   typedef logic [1:0] mode_t;

   localparam mode_t MODE_BIN     = 2'd0;
   localparam mode_t MODE_GRAY    = 2'd1;
   localparam mode_t MODE_ONEHOT  = 2'd2;
   localparam mode_t MODE_JOHNSON = 2'd3;

endpackage

// File: rtl/state_enc.sv
// rtl/state_enc.sv - combinational index-to-code mapping for all four modes
module state_enc
   import state_seq_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  mode_t            mode,
   input  logic [WIDTH-1:0] idx,
   output logic [WIDTH-1:0] code
);

   always_comb begin
      code = '0;
      case (mode)
         MODE_BIN:  code = idx;
         MODE_GRAY: code = idx ^ (idx >> 1);
         MODE_ONEHOT: begin
            for (int i = 0; i < WIDTH; i++) begin
               code[i] = (idx == WIDTH'(i));
            end
         end
         default: begin
            // Johnson: fill ones from the LSB, then drain them from the LSB
            for (int i = 0; i < WIDTH; i++) begin
               if (idx <= WIDTH'(WIDTH)) begin
                  code[i] = (WIDTH'(i) < idx);
               end else begin
                  code[i] = (WIDTH'(i) >= (idx - WIDTH'(WIDTH)));
               end
            end
         end
      endcase
   end

endmodule

// File: rtl/state_seq.sv
// rtl/state_seq.sv - index sequencer with selectable binary/Gray/one-hot/Johnson output
module state_seq
   import state_seq_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic             i_dir,
   input  mode_t            i_mode,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_idx,
   output logic [WIDTH-1:0] o_state,
   output logic [WIDTH-1:0] o_idx,
   output logic             o_wrap,
   output logic             o_err
);

   mode_t            mode_q;
   mode_t            mode_d;
   logic [WIDTH-1:0] idx_max;
   logic [WIDTH-1:0] idx_d;
   logic [WIDTH-1:0] code_d;
   logic             wrap_d;
   logic             err_d;

   // Highest legal index (period - 1) for the active mode
   always_comb begin
      idx_max = '1;
      case (mode_q)
         MODE_BIN, MODE_GRAY: idx_max = '1;
         MODE_ONEHOT:         idx_max = WIDTH'(WIDTH - 1);
         default:             idx_max = WIDTH'(2 * WIDTH - 1);
      endcase
   end

   always_comb begin
      mode_d = mode_q;
      idx_d  = o_idx;
      wrap_d = 1'b0;
      err_d  = 1'b0;
      if (i_mode != mode_q) begin
         mode_d = i_mode;
         idx_d  = '0;
      end else if (i_load) begin
         if (i_load_idx <= idx_max) begin
            idx_d = i_load_idx;
         end else begin
            idx_d = idx_max;
            err_d = 1'b1;
         end
      end else if (i_en) begin
         if (i_dir) begin
            if (o_idx == idx_max) begin
               idx_d  = '0;
               wrap_d = 1'b1;
            end else begin
               idx_d = o_idx + WIDTH'(1);
            end
         end else begin
            if (o_idx == '0) begin
               idx_d  = idx_max;
               wrap_d = 1'b1;
            end else begin
               idx_d = o_idx - WIDTH'(1);
            end
         end
      end
   end

   // Encoding the next index keeps o_state aligned with o_idx on the same edge
   state_enc #(
      .WIDTH (WIDTH)
   ) u_enc (
      .mode (mode_d),
      .idx  (idx_d),
      .code (code_d)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         mode_q  <= MODE_BIN;
         o_idx   <= '0;
         o_state <= '0;
         o_wrap  <= 1'b0;
         o_err   <= 1'b0;
      end else begin
         mode_q  <= mode_d;
         o_idx   <= idx_d;
         o_state <= code_d;
         o_wrap  <= wrap_d;
         o_err   <= err_d;
      end
   end

endmodule

// File: tb/tb_state_seq.sv
// tb/tb_state_seq.sv - directed vector table, corner sequences and randomized model check
module tb_state_seq;
   import state_seq_pkg::*;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         en;
   logic         dir;
   logic         load;
   mode_t        mode;
   logic [W-1:0] load_idx;
   logic [W-1:0] state;
   logic [W-1:0] idx;
   logic         wrap;
   logic         err;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   state_seq #(
      .WIDTH (W)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_en       (en),
      .i_dir      (dir),
      .i_mode     (mode),
      .i_load     (load),
      .i_load_idx (load_idx),
      .o_state    (state),
      .o_idx      (idx),
      .o_wrap     (wrap),
      .o_err      (err)
   );

   typedef struct {
      logic         en;
      logic         dir;
      logic         load;
      mode_t        mode;
      logic [W-1:0] lidx;
      logic [W-1:0] st;
      logic [W-1:0] ix;
      logic         wr;
      logic         er;
   } vec_t;

   vec_t vecs[$];

   logic [W-1:0] gray_seq[16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101,
                                  4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010,
                                  4'b1011, 4'b1001, 4'b1000, 4'b0000};
   logic [W-1:0] john_seq[8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                 4'b1110, 4'b1100, 4'b1000, 4'b0000};

   // Reference model state
   int   m_mode;
   int   m_idx;
   logic ew;
   logic ee;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [W-1:0] st, input logic [W-1:0] ix,
                          input logic wr, input logic er);
      chk({tag, ".state"}, 32'(state), 32'(st));
      chk({tag, ".idx"},   32'(idx),   32'(ix));
      chk({tag, ".wrap"},  32'(wrap),  32'(wr));
      chk({tag, ".err"},   32'(err),   32'(er));
   endtask

   function automatic void add(input logic a_en, input logic a_dir, input logic a_load,
                               input mode_t a_mode, input logic [W-1:0] a_lidx,
                               input logic [W-1:0] a_st, input logic [W-1:0] a_ix,
                               input logic a_wr, input logic a_er);
      vec_t v;
      v.en = a_en; v.dir = a_dir; v.load = a_load; v.mode = a_mode; v.lidx = a_lidx;
      v.st = a_st; v.ix = a_ix; v.wr = a_wr; v.er = a_er;
      vecs.push_back(v);
   endfunction

   function automatic int period(input int md);
      case (md)
         0, 1:    return 1 << W;
         2:       return W;
         default: return 2 * W;
      endcase
   endfunction

   function automatic int encode(input int md, input int k);
      case (md)
         0:       return k;
         1:       return k ^ (k >> 1);
         2:       return 1 << k;
         default: return (k <= W) ? (1 << k) - 1 : ((1 << W) - 1) - ((1 << (k - W)) - 1);
      endcase
   endfunction

   task automatic model_edge();
      int p;
      ew = 1'b0;
      ee = 1'b0;
      if (int'(mode) != m_mode) begin
         m_mode = int'(mode);
         m_idx  = 0;
      end else if (load) begin
         p = period(m_mode);
         if (int'(load_idx) < p) begin
            m_idx = int'(load_idx);
         end else begin
            m_idx = p - 1;
            ee    = 1'b1;
         end
      end else if (en) begin
         p     = period(m_mode);
         m_idx = dir ? m_idx + 1 : m_idx - 1;
         if (m_idx >= p) begin m_idx = 0;     ew = 1'b1; end
         if (m_idx < 0)  begin m_idx = p - 1; ew = 1'b1; end
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; dir = 1'b0; load = 1'b0; mode = MODE_BIN; load_idx = '0;

      #3;
      chk_all("reset_async", '0, '0, 1'b0, 1'b0);
      cyc();
      chk_all("reset_held", '0, '0, 1'b0, 1'b0);
      #3 rst_n = 1'b1;

      // Binary count-up with wrap
      for (int k = 1; k <= 16; k++)
         add(1, 1, 0, MODE_BIN, 0, W'(k % 16), W'(k % 16), k == 16, 0);
      // Gray: mode change cycle, then 16 steps
      add(1, 1, 0, MODE_GRAY, 0, 4'b0000, 0, 0, 0);
      for (int k = 1; k <= 16; k++)
         add(1, 1, 0, MODE_GRAY, 0, gray_seq[k-1], W'(k % 16), k == 16, 0);
      // One-hot: mode change with en held, then down-steps
      add(1, 1, 0, MODE_ONEHOT, 0, 4'b0001, 0, 0, 0);
      add(1, 0, 0, MODE_ONEHOT, 0, 4'b1000, 3, 1, 0);
      add(1, 0, 0, MODE_ONEHOT, 0, 4'b0100, 2, 0, 0);
      add(1, 0, 0, MODE_ONEHOT, 0, 4'b0010, 1, 0, 0);
      // One-hot loads, including out-of-range and boundary values
      add(1, 1, 1, MODE_ONEHOT, 9, 4'b1000, 3, 0, 1);
      add(0, 0, 1, MODE_ONEHOT, 2, 4'b0100, 2, 0, 0);
      add(0, 1, 0, MODE_ONEHOT, 5, 4'b0100, 2, 0, 0);
      add(1, 1, 1, MODE_ONEHOT, 0, 4'b0001, 0, 0, 0);
      add(0, 0, 1, MODE_ONEHOT, 3, 4'b1000, 3, 0, 0);
      add(0, 0, 1, MODE_ONEHOT, 4, 4'b1000, 3, 0, 1);
      // Johnson: mode change, 8 steps up, one down-wrap
      add(1, 1, 0, MODE_JOHNSON, 0, 4'b0000, 0, 0, 0);
      for (int k = 1; k <= 8; k++)
         add(1, 1, 0, MODE_JOHNSON, 0, john_seq[k-1], W'(k % 8), k == 8, 0);
      add(1, 0, 0, MODE_JOHNSON, 0, 4'b1000, 7, 1, 0);

      foreach (vecs[i]) begin
         en = vecs[i].en; dir = vecs[i].dir; load = vecs[i].load;
         mode = vecs[i].mode; load_idx = vecs[i].lidx;
         cyc();
         chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].ix, vecs[i].wr, vecs[i].er);
      end

      // Asynchronous reset in the middle of a Johnson run
      en = 1'b1; dir = 1'b1; load = 1'b0; mode = MODE_JOHNSON;
      cyc(); chk_all("jrun0", 4'b0000, 0, 1'b1, 1'b0);
      cyc(); chk_all("jrun1", 4'b0001, 1, 1'b0, 1'b0);
      cyc(); chk_all("jrun2", 4'b0011, 2, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1 chk_all("rst_mid", '0, '0, 1'b0, 1'b0);
      cyc(); chk_all("rst_hold", '0, '0, 1'b0, 1'b0);
      #3 rst_n = 1'b1;
      cyc(); chk_all("post_rst_mode", 4'b0000, 0, 1'b0, 1'b0);
      cyc(); chk_all("post_rst_s1", 4'b0001, 1, 1'b0, 1'b0);
      cyc(); chk_all("post_rst_s2", 4'b0011, 2, 1'b0, 1'b0);

      // Mode change beats a simultaneous out-of-range load
      mode = MODE_ONEHOT; load = 1'b1; load_idx = 4'd9; en = 1'b1;
      cyc(); chk_all("mode_vs_load", 4'b0001, 0, 1'b0, 1'b0);
      load = 1'b0; en = 1'b0;
      cyc(); chk_all("hold_after", 4'b0001, 0, 1'b0, 1'b0);

      // Randomized run against the reference model
      rst_n = 1'b0;
      #1 rst_n = 1'b1;
      m_mode = 0;
      m_idx  = 0;
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 7) == 0) mode = mode_t'($urandom_range(0, 3));
         load     = ($urandom_range(0, 7) == 0);
         load_idx = W'($urandom);
         en       = ($urandom_range(0, 3) != 0);
         dir      = 1'($urandom_range(0, 1));
         model_edge();
         cyc();
         chk_all($sformatf("rand%0d", n), W'(encode(m_mode, m_idx)), W'(m_idx), ew, ee);
         if ($urandom_range(0, 249) == 0) begin
            rst_n = 1'b0;
            #1 chk_all($sformatf("rand_rst%0d", n), '0, '0, 1'b0, 1'b0);
            rst_n  = 1'b1;
            m_mode = 0;
            m_idx  = 0;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
